// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: RV32 fetch stage with req/gnt/rvalid imem port, prefetch FIFO and redirect flush
module fetch_prefetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] PC_RESET   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            de_valid,
    input  logic            de_ready,
    output logic [XLEN-1:0] de_pc,
    output logic [XLEN-1:0] de_instr
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc, resp_pc, last_pc, last_instr, target;
    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [NW-1:0]   count;
    logic [CW-1:0]   outst, drop;
    logic            empty, fire, rsp, push, pop;

    // Issue gating, response acceptance and decode handshake
    always_comb begin
        target    = redirect_pc & ~XLEN'(3);
        empty     = (count == '0);
        imem_req  = rst_n & !redirect & (int'(outst) < MAX_OUTST)
                  & (int'(count) + int'(outst) < FIFO_DEPTH);
        imem_addr = fetch_pc;
        fire      = imem_req & imem_gnt;
        rsp       = imem_rvalid & (outst != '0);
        push      = rsp & (drop == '0) & !redirect;
        de_valid  = rst_n & !empty & !redirect;
        pop       = de_valid & de_ready;
        de_pc     = !rst_n ? '0 : empty ? last_pc    : pc_mem[rd_ptr];
        de_instr  = !rst_n ? '0 : empty ? last_instr : instr_mem[rd_ptr];
    end

    // Prefetch storage; written only when an undropped response arrives
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    // PCs, FIFO pointers, outstanding and drop counters; redirect overrides everything but outst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc   <= PC_RESET;
            resp_pc    <= PC_RESET;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            outst      <= '0;
            drop       <= '0;
            last_pc    <= '0;
            last_instr <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop     <= outst + CW'(fire) - CW'(rsp);
            end else begin
                if (fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (rsp && drop != '0)
                    drop <= drop - CW'(1);
                if (pop) begin
                    rd_ptr     <= rd_ptr + AW'(1);
                    last_pc    <= pc_mem[rd_ptr];
                    last_instr <= instr_mem[rd_ptr];
                end
                count <= count + NW'(push) - NW'(pop);
            end
            outst <= outst + CW'(fire) - CW'(rsp);
        end
    end
endmodule
